// File: rtl/hub75_pkg.sv
// Shared definitions for the hub75 frame scheduler: FSM state encodings and
// the modulo-N frame-buffer index increment.
package hub75_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;

    function automatic int unsigned fb_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/hub75_fsched_hold.sv
// Saturating frames-since-last-swap counter with minimum-hold eligibility
// compare; a zero hold setting behaves as one.
module hub75_fsched_hold #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              tick_i,
    input  logic [HOLD_W-1:0] cfg_hold_i,
    output logic              elig_o
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] cnt_inc;
    logic [HOLD_W-1:0] hold_min;

    always_comb begin
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        hold_min = (cfg_hold_i == '0) ? HOLD_W'(1) : cfg_hold_i;
        // Eligibility looks at the count as it would be after this frame_start.
        elig_o   = (cnt_inc >= hold_min);
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hub75_frame_sched.sv
// Tear-free frame-buffer swap scheduler for hub75_top with software handshake.
// Optional statistics counters enabled by defining HUB75_FSCHED_STATS_EN.
module hub75_frame_sched
    import hub75_pkg::*;
#(
    parameter int unsigned N_FB     = 2,
    parameter int unsigned LOG_N_FB = $clog2(N_FB),
    parameter int unsigned HOLD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic [LOG_N_FB-1:0] frame_cur,
    output logic [LOG_N_FB-1:0] frame_req,
    input  logic                sw_swap_req,
    output logic [LOG_N_FB-1:0] sw_wr_frame,
    output logic                sw_busy,
    output logic                sw_swap_done,
    input  logic [HOLD_W-1:0]   cfg_hold,
    input  logic                cfg_auto,
    output logic [15:0]         stat_frames,
    output logic [7:0]          stat_overruns
);

    logic [1:0]          state_q, state_d;
    logic [LOG_N_FB-1:0] req_q, req_d;
    logic [LOG_N_FB-1:0] wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hold_clr;
    logic                elig;

    hub75_fsched_hold #(
        .HOLD_W(HOLD_W)
    ) u_hold (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (hold_clr),
        .tick_i     (frame_start),
        .cfg_hold_i (cfg_hold),
        .elig_o     (elig)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hold_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_swap_req || cfg_auto) begin
                    state_d = ST_PENDING;
                    busy_d  = 1'b1;
                end
            end
            ST_PENDING: begin
                // frame_req may only move right after frame_start.
                if (frame_start && elig) begin
                    state_d  = ST_SWAP;
                    req_d    = wr_q;
                    hold_clr = 1'b1;
                end
            end
            ST_SWAP: begin
                if (frame_cur == req_q) begin
                    wr_d    = LOG_N_FB'(fb_inc(32'(req_q), N_FB));
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            wr_q    <= LOG_N_FB'(1);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign frame_req    = req_q;
    assign sw_wr_frame  = wr_q;
    assign sw_busy      = busy_q;
    assign sw_swap_done = done_q;

`ifdef HUB75_FSCHED_STATS_EN
    logic [15:0] frames_q;
    logic [7:0]  ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q <= '0;
            ovr_q    <= '0;
        end else begin
            if (frame_start) begin
                frames_q <= frames_q + 16'd1;
            end
            if (sw_swap_req && busy_q && (ovr_q != '1)) begin
                ovr_q <= ovr_q + 8'd1;
            end
        end
    end

    assign stat_frames   = frames_q;
    assign stat_overruns = ovr_q;
`else
    assign stat_frames   = '0;
    assign stat_overruns = '0;
`endif

endmodule

// File: tb/tb_hub75_frame_sched.sv
// Directed bench for hub75_frame_sched (N_FB=2 and N_FB=3 instances) with a
// swap-completion scoreboard.
module tb_hub75_frame_sched;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] wr;
    } exp_t;

`ifdef HUB75_FSCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        fs2 = 1'b0, req2_in = 1'b0, auto2 = 1'b0;
    logic [7:0]  hold2 = 8'd1;
    logic        cur2;
    logic        req2, wr2, busy2, done2;
    logic [15:0] frames2;
    logic [7:0]  ovr2;

    logic        fs3 = 1'b0, req3_in = 1'b0, auto3 = 1'b0;
    logic [7:0]  hold3 = 8'd1;
    logic [1:0]  cur3;
    logic [1:0]  req3, wr3;
    logic        busy3, done3;
    logic [15:0] frames3;
    logic [7:0]  ovr3;

    int checks = 0;
    int errors = 0;
    int fs_cnt2 = 0;
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    hub75_frame_sched #(.N_FB(2), .HOLD_W(8)) dut2 (
        .clk(clk), .rst(rst), .frame_start(fs2), .frame_cur(cur2), .frame_req(req2),
        .sw_swap_req(req2_in), .sw_wr_frame(wr2), .sw_busy(busy2), .sw_swap_done(done2),
        .cfg_hold(hold2), .cfg_auto(auto2), .stat_frames(frames2), .stat_overruns(ovr2)
    );

    hub75_frame_sched #(.N_FB(3), .HOLD_W(8)) dut3 (
        .clk(clk), .rst(rst), .frame_start(fs3), .frame_cur(cur3), .frame_req(req3),
        .sw_swap_req(req3_in), .sw_wr_frame(wr3), .sw_busy(busy3), .sw_swap_done(done3),
        .cfg_hold(hold3), .cfg_auto(auto3), .stat_frames(frames3), .stat_overruns(ovr3)
    );

    // hub75_top model: applies frame_req one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur2 <= 1'b0;
            cur3 <= 2'd0;
        end else begin
            cur2 <= req2;
            cur3 <= req3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs2();
        fs2 = 1'b1;
        step(1);
        fs2 = 1'b0;
        fs_cnt2++;
    endtask

    task automatic pulse_req2();
        req2_in = 1'b1;
        step(1);
        req2_in = 1'b0;
    endtask

    task automatic pulse_fs3();
        fs3 = 1'b1;
        step(1);
        fs3 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && done2) begin
            chk("sb2_done_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                exp_t e;
                e = q2.pop_front();
                chk("sb2_frame_req", 32'(req2), 32'(e.req));
                chk("sb2_wr_frame", 32'(wr2), 32'(e.wr));
                chk("sb2_wr_ne_req", 32'(wr2 != req2), 32'd1);
            end
        end
        if (!rst && done3) begin
            chk("sb3_done_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                exp_t e;
                e = q3.pop_front();
                chk("sb3_frame_req", 32'(req3), 32'(e.req));
                chk("sb3_wr_frame", 32'(wr3), 32'(e.wr));
            end
        end
    end

    initial begin
        exp_t e;
        logic [1:0] m_req;
        logic [1:0] m_wr;

        // Reset state
        step(3);
        chk("rst_frame_req", 32'(req2), 32'd0);
        chk("rst_wr_frame", 32'(wr2), 32'd1);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_done", 32'(done2), 32'd0);
        chk("rst_frames", 32'(frames2), 32'd0);
        chk("rst_overruns", 32'(ovr2), 32'd0);
        chk("rst3_wr_frame", 32'(wr3), 32'd1);
        rst = 1'b0;
        step(2);

        // Basic swap latency: request at T, frame_start at T+10
        e.req = 8'd1; e.wr = 8'd0; q2.push_back(e);
        pulse_req2();
        chk("t1_busy_set", 32'(busy2), 32'd1);
        step(9);
        chk("t1_req_before", 32'(req2), 32'd0);
        pulse_fs2();
        chk("t1_req_after", 32'(req2), 32'd1);
        step(1);
        chk("t1_done_t12", 32'(done2), 32'd0);
        step(1);
        chk("t1_done_t13", 32'(done2), 32'd1);
        chk("t1_wr_frame", 32'(wr2), 32'd0);
        chk("t1_busy_clr", 32'(busy2), 32'd0);
        step(1);
        chk("t1_done_pulse", 32'(done2), 32'd0);

        // Reset while pending: immediate reset values, no done afterwards
        pulse_req2();
        step(3);
        chk("rp_busy", 32'(busy2), 32'd1);
        rst = 1'b1;
        #1;
        chk("rp_frame_req", 32'(req2), 32'd0);
        chk("rp_wr_frame", 32'(wr2), 32'd1);
        chk("rp_busy_clr", 32'(busy2), 32'd0);
        step(2);
        rst = 1'b0;
        fs_cnt2 = 0;
        step(3);
        pulse_fs2();
        step(6);
        chk("rp_no_swap", 32'(req2), 32'd0);
        chk("rp_idle", 32'(busy2), 32'd0);

        // Request coincident with frame_start in IDLE: swap deferred one frame
        e.req = 8'd1; e.wr = 8'd0; q2.push_back(e);
        fs2 = 1'b1;
        req2_in = 1'b1;
        step(1);
        fs2 = 1'b0;
        req2_in = 1'b0;
        fs_cnt2++;
        chk("sc_no_swap", 32'(req2), 32'd0);
        chk("sc_busy", 32'(busy2), 32'd1);
        step(20);
        pulse_fs2();
        chk("sc_swap_next", 32'(req2), 32'd1);
        step(5);
        chk("sc_idle", 32'(busy2), 32'd0);

        // Hold of 3 frames: swap on the 3rd frame_start after the last swap
        hold2 = 8'd3;
        e.req = 8'd0; e.wr = 8'd1; q2.push_back(e);
        pulse_req2();
        for (int i = 0; i < 3; i++) begin
            step(99);
            pulse_fs2();
            chk("hold_frame_req", 32'(req2), (i < 2) ? 32'd1 : 32'd0);
        end
        step(5);
        chk("hold_idle", 32'(busy2), 32'd0);

        // Overruns: two requests while busy, exactly one swap
        hold2 = 8'd0;
        e.req = 8'd1; e.wr = 8'd0; q2.push_back(e);
        pulse_req2();
        step(2);
        pulse_req2();
        step(2);
        pulse_req2();
        step(2);
        pulse_fs2();
        chk("ovr_swap", 32'(req2), 32'd1);
        step(5);
        pulse_fs2();
        step(5);
        chk("ovr_single_swap", 32'(req2), 32'd1);
        chk("ovr_idle", 32'(busy2), 32'd0);
        chk("stat_overruns", 32'(ovr2), STATS ? 32'd2 : 32'd0);
        chk("stat_frames", 32'(frames2), STATS ? 32'(fs_cnt2) : 32'd0);

        // N_FB=3 auto-cycle: 0->1->2->0->1, then auto dropped while pending
        m_req = 2'd0;
        m_wr  = 2'd1;
        auto3 = 1'b1;
        step(2);
        for (int i = 0; i < 5; i++) begin
            m_req = m_wr;
            m_wr  = (m_req == 2'd2) ? 2'd0 : m_req + 2'd1;
            e.req = 8'(m_req); e.wr = 8'(m_wr); q3.push_back(e);
            if (i == 4) begin
                auto3 = 1'b0;
                step(1);
            end
            pulse_fs3();
            chk("auto_frame_req", 32'(req3), 32'(m_req));
            step(10);
        end
        pulse_fs3();
        step(5);
        chk("auto_stopped", 32'(req3), 32'(m_req));
        chk("auto_idle", 32'(busy3), 32'd0);

        step(5);
        chk("sb2_drained", 32'(q2.size()), 32'd0);
        chk("sb3_drained", 32'(q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
